// File: rtl/io_ctrl.sv
// Memory-mapped I/O slave: millisecond timer, LED/switch registers, 8N1 UART.
// Build option IO_UART_LOOPBACK_EN feeds the receiver from the internal txd.
//
// UART FSM states (shared by TX and RX):
//   state   | meaning
//   S_IDLE  | line idle, waiting for a write (TX) or falling edge (RX)
//   S_START | start bit; RX re-checks the line at mid-bit
//   S_DATA  | eight data bits, LSB first
//   S_STOP  | stop bit; TX sets tx_rdy, RX accepts the byte if line high
module io_ctrl #(
  parameter int CLK_FREQ = 50000000,
  parameter int BAUD     = 115200
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stb,
  input  logic        we,
  input  logic [3:0]  addr,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        ack,
  output logic [7:0]  led,
  input  logic [7:0]  sw,
  input  logic        rxd,
  output logic        txd
);

  localparam int BIT_DIV = CLK_FREQ / BAUD;
  localparam int MS_DIV  = CLK_FREQ / 1000;
  localparam int BW      = $clog2(BIT_DIV + 1);
  localparam int MW      = $clog2(MS_DIV + 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(BIT_DIV - 1);
  localparam logic [BW-1:0] HALF_LAST = BW'(BIT_DIV / 2 - 1);
  localparam logic [MW-1:0] MS_LAST   = MW'(MS_DIV - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} uart_state_t;

  logic          start, rd_clr, tx_start;
  logic [31:0]   rd_mux;
  logic [MW-1:0] ms_pre;
  logic [31:0]   ms_cnt;
  logic [7:0]    sw_s1, sw_sync;
  logic          rx_in, rx_s1, rx_s2, rx_prev, rx_fall;

  uart_state_t   tx_state, tx_next;
  logic [BW-1:0] tx_tmr;
  logic [2:0]    tx_bit;
  logic [7:0]    tx_shift;
  logic          tx_rdy, tx_tc;

  uart_state_t   rx_state, rx_next;
  logic [BW-1:0] rx_tmr;
  logic [2:0]    rx_bit;
  logic [7:0]    rx_shift, rx_data;
  logic          rx_rdy, rx_tc, rx_set;

  assign start    = stb & ~ack;
  assign rd_clr   = start & ~we & (addr == 4'd2);
  assign tx_start = start & we & (addr == 4'd2) & tx_rdy;

  always_comb begin
    rd_mux = 32'd0;
    case (addr)
      4'd0:    rd_mux = ms_cnt;
      4'd1:    rd_mux = {24'd0, sw_sync};
      4'd2:    rd_mux = {24'd0, rx_data};
      4'd3:    rd_mux = {30'd0, tx_rdy, rx_rdy};
      default: rd_mux = 32'd0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack      <= 1'b0;
      data_out <= 32'd0;
      led      <= 8'd0;
    end else begin
      ack      <= start;
      data_out <= (start && !we) ? rd_mux : 32'd0;
      if (start && we && addr == 4'd1) led <= data_in[7:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ms_pre <= MS_LAST;
      ms_cnt <= 32'd0;
    end else if (ms_pre == '0) begin
      ms_pre <= MS_LAST;
      ms_cnt <= ms_cnt + 32'd1;
    end else begin
      ms_pre <= ms_pre - 1'b1;
    end
  end

`ifdef IO_UART_LOOPBACK_EN
  assign rx_in = txd;
`else
  assign rx_in = rxd;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_s1   <= 8'd0;
      sw_sync <= 8'd0;
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      sw_s1   <= sw;
      sw_sync <= sw_s1;
      rx_s1   <= rx_in;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

  assign rx_fall = rx_prev & ~rx_s2;
  assign tx_tc   = (tx_tmr == '0);
  assign rx_tc   = (rx_tmr == '0);

  // ---------------- transmitter ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tx_state <= S_IDLE;
    else        tx_state <= tx_next;
  end

  always_comb begin
    tx_next = tx_state;
    case (tx_state)
      S_IDLE:  if (tx_start) tx_next = S_START;
      S_START: if (tx_tc) tx_next = S_DATA;
      S_DATA:  if (tx_tc && tx_bit == 3'd7) tx_next = S_STOP;
      S_STOP:  if (tx_tc) tx_next = S_IDLE;
      default: tx_next = S_IDLE;
    endcase
  end

  always_comb begin
    txd = 1'b1;
    case (tx_state)
      S_START: txd = 1'b0;
      S_DATA:  txd = tx_shift[0];
      default: txd = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_tmr   <= '0;
      tx_bit   <= 3'd0;
      tx_shift <= 8'd0;
      tx_rdy   <= 1'b1;
    end else if (tx_start) begin
      tx_tmr   <= BIT_LAST;
      tx_bit   <= 3'd0;
      tx_shift <= data_in[7:0];
      tx_rdy   <= 1'b0;
    end else if (tx_state != S_IDLE) begin
      if (tx_tc) begin
        tx_tmr <= BIT_LAST;
        if (tx_state == S_DATA) begin
          tx_shift <= {1'b1, tx_shift[7:1]};
          tx_bit   <= tx_bit + 3'd1;
        end
        if (tx_state == S_STOP) tx_rdy <= 1'b1;
      end else begin
        tx_tmr <= tx_tmr - 1'b1;
      end
    end
  end

  // ---------------- receiver ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rx_state <= S_IDLE;
    else        rx_state <= rx_next;
  end

  always_comb begin
    rx_next = rx_state;
    case (rx_state)
      S_IDLE:  if (rx_fall) rx_next = S_START;
      S_START: if (rx_tc) rx_next = rx_s2 ? S_IDLE : S_DATA;
      S_DATA:  if (rx_tc && rx_bit == 3'd7) rx_next = S_STOP;
      S_STOP:  if (rx_tc) rx_next = S_IDLE;
      default: rx_next = S_IDLE;
    endcase
  end

  always_comb begin
    rx_set = (rx_state == S_STOP) && rx_tc && rx_s2;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_tmr   <= '0;
      rx_bit   <= 3'd0;
      rx_shift <= 8'd0;
      rx_data  <= 8'd0;
    end else if (rx_state == S_IDLE) begin
      rx_bit <= 3'd0;
      if (rx_fall) rx_tmr <= HALF_LAST;
    end else if (rx_tc) begin
      rx_tmr <= BIT_LAST;
      if (rx_state == S_DATA) begin
        rx_shift <= {rx_s2, rx_shift[7:1]};
        rx_bit   <= rx_bit + 3'd1;
      end
      if (rx_set) rx_data <= rx_shift;
    end else begin
      rx_tmr <= rx_tmr - 1'b1;
    end
  end

  // A byte landing on the same edge as a clearing read keeps rx_rdy set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      rx_rdy <= 1'b0;
    else if (rx_set) rx_rdy <= 1'b1;
    else if (rd_clr) rx_rdy <= 1'b0;
  end

endmodule

// File: tb/tb_io_ctrl.sv
// Self-checking bench for io_ctrl at CLK_FREQ=16000, BAUD=1000 (16 clocks per bit and per ms).
module tb_io_ctrl;

  localparam int CLK_FREQ = 16000;
  localparam int BAUD     = 1000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stb = 1'b0;
  logic        we = 1'b0;
  logic [3:0]  addr = 4'd0;
  logic [31:0] data_in = 32'd0;
  logic [31:0] data_out;
  logic        ack;
  logic [7:0]  led;
  logic [7:0]  sw = 8'd0;
  logic        rxd = 1'b1;
  logic        txd;
  bit          clk_en = 1'b1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          chk;
    logic [31:0] exp;
    int          tol;
    string       name;
  } sb_t;
  sb_t sb_q[$];

  typedef struct {
    bit          wr;
    logic [3:0]  a;
    logic [31:0] wdata;
    logic [31:0] exp;
    logic [7:0]  exp_led;
    string       name;
  } vec_t;
  vec_t vecs[11];

  io_ctrl #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
    .clk(clk), .rst_n(rst_n), .stb(stb), .we(we), .addr(addr),
    .data_in(data_in), .data_out(data_out), .ack(ack), .led(led),
    .sw(sw), .rxd(rxd), .txd(txd)
  );

  initial forever begin
    #5;
    if (clk_en) clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic check_tol(input string name, input logic [31:0] act, input logic [31:0] exp,
                           input int tol);
    checks++;
    if ((act === 32'bx) || (act + tol < exp) || (act > exp + tol)) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h +/- %0d", name, act, exp, tol);
    end
  endtask

  // One bus access; the expected response is queued when driven and popped on ack.
  task automatic bus_xfer(input bit wr, input logic [3:0] a, input logic [31:0] d,
                          input bit chk, input logic [31:0] exp, input int tol,
                          input string name);
    sb_t e;
    int  n;
    e.chk = chk; e.exp = exp; e.tol = tol; e.name = name;
    sb_q.push_back(e);
    @(negedge clk);
    stb = 1'b1; we = wr; addr = a; data_in = d;
    @(negedge clk);
    stb = 1'b0; we = 1'b0;
    n = 0;
    while (!ack && n < 8) begin
      @(negedge clk);
      n++;
    end
    e = sb_q.pop_front();
    if (!ack) begin
      checks++;
      errors++;
      $display("FAIL %s: ack timeout, got ack=%b expected 1", e.name, ack);
    end else if (e.chk) begin
      check_tol(e.name, data_out, e.exp, e.tol);
    end else begin
      check({e.name, "_ack"}, {31'd0, ack}, 32'd1);
    end
  endtask

  task automatic rd(input logic [3:0] a, input logic [31:0] exp, input string name);
    bus_xfer(1'b0, a, 32'd0, 1'b1, exp, 0, name);
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d, input string name);
    bus_xfer(1'b1, a, d, 1'b0, 32'd0, 0, name);
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop_bit);
    logic [9:0] frame;
    frame = {stop_bit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      rxd = frame[i];
      repeat (15) @(negedge clk);
    end
    @(negedge clk);
    rxd = 1'b1;
  endtask

  task automatic set_vec(input int i, input bit w, input logic [3:0] a, input logic [31:0] d,
                         input logic [31:0] exp, input logic [7:0] l, input string name);
    vecs[i].wr = w; vecs[i].a = a; vecs[i].wdata = d;
    vecs[i].exp = exp; vecs[i].exp_led = l; vecs[i].name = name;
  endtask

  initial begin
    logic [7:0] txb;
    logic [9:0] frame;
    logic       bad, prev;
    int         falls;

    set_vec(0,  1'b1, 4'd1,  32'h123456A5, 32'h0,        8'hA5, "led_wr");
    set_vec(1,  1'b0, 4'd1,  32'h0,        32'h0000003C, 8'hA5, "sw_rd");
    set_vec(2,  1'b1, 4'd0,  32'hDEADBEEF, 32'h0,        8'hA5, "ms_wr_ign");
    set_vec(3,  1'b1, 4'd3,  32'hFFFFFFFF, 32'h0,        8'hA5, "stat_wr_ign");
    set_vec(4,  1'b0, 4'd3,  32'h0,        32'h00000002, 8'hA5, "stat_rd");
    set_vec(5,  1'b1, 4'd7,  32'hFFFFFFFF, 32'h0,        8'hA5, "a7_wr_ign");
    set_vec(6,  1'b0, 4'd7,  32'h0,        32'h0,        8'hA5, "a7_rd");
    set_vec(7,  1'b0, 4'd4,  32'h0,        32'h0,        8'hA5, "a4_rd");
    set_vec(8,  1'b0, 4'd15, 32'h0,        32'h0,        8'hA5, "a15_rd");
    set_vec(9,  1'b1, 4'd1,  32'h0000005A, 32'h0,        8'h5A, "led_wr2");
    set_vec(10, 1'b0, 4'd1,  32'h0,        32'h0000003C, 8'h5A, "sw_rd2");

    repeat (3) @(negedge clk);
    check("rst_led", {24'd0, led}, 32'h0);
    check("rst_txd", {31'd0, txd}, 32'h1);
    check("rst_ack", {31'd0, ack}, 32'h0);
    rst_n = 1'b1;

    // timer: 160 clocks after reset is 10 ms ticks
    repeat (159) @(negedge clk);
    bus_xfer(1'b0, 4'd0, 32'd0, 1'b1, 32'h0000000A, 1, "ms_160");

    @(negedge clk);
    force dut.ms_cnt = 32'hFFFFFFFF;
    @(negedge clk);
    release dut.ms_cnt;
    repeat (15) @(negedge clk);
    rd(4'd0, 32'h0, "ms_wrap");

    sw = 8'h3C;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 11; i++) begin
      bus_xfer(vecs[i].wr, vecs[i].a, vecs[i].wdata, !vecs[i].wr, vecs[i].exp, 0, vecs[i].name);
      check({vecs[i].name, "_led"}, {24'd0, led}, {24'd0, vecs[i].exp_led});
    end

    // back-to-back reads with stb held high: ack 1,0,1
    @(negedge clk);
    stb = 1'b1; we = 1'b0; addr = 4'd3;
    @(negedge clk);
    check("b2b_ack0", {31'd0, ack}, 32'h1);
    check("b2b_dat0", data_out, 32'h2);
    @(negedge clk);
    check("b2b_ack1", {31'd0, ack}, 32'h0);
    check("b2b_dat1", data_out, 32'h0);
    @(negedge clk);
    check("b2b_ack2", {31'd0, ack}, 32'h1);
    stb = 1'b0;
    @(negedge clk);

`ifdef IO_UART_LOOPBACK_EN
    wr(4'd2, 32'h7E, "lb_tx");
    repeat (160) @(negedge clk);
    rd(4'd3, 32'h3, "lb_stat");
    rd(4'd2, 32'h7E, "lb_data");
    rd(4'd3, 32'h2, "lb_stat_clr");
`else
    // TX frame for 0x55, sampled every clock of every bit
    txb = 8'h55;
    frame = {1'b1, txb, 1'b0};
    wr(4'd2, 32'h55, "tx_wr");
    for (int b = 0; b < 10; b++) begin
      bad = 1'b0;
      for (int k = 0; k < 16; k++) begin
        if (txd !== frame[b]) bad = 1'b1;
        @(negedge clk);
      end
      check($sformatf("tx_bit%0d_exp%0d", b, frame[b]), {31'd0, bad}, 32'h0);
    end
    rd(4'd3, 32'h2, "tx_stat_done");

    // mid-frame write is dropped: no second start bit
    wr(4'd2, 32'hFF, "tx_wr_ff");
    repeat (40) @(negedge clk);
    rd(4'd3, 32'h0, "tx_stat_busy");
    wr(4'd2, 32'hF0, "tx_wr_drop");
    falls = 0;
    prev = txd;
    for (int k = 0; k < 260; k++) begin
      @(negedge clk);
      if (prev && !txd) falls++;
      prev = txd;
    end
    check("tx_drop_falls", falls, 32'd0);
    check("tx_idle_txd", {31'd0, txd}, 32'h1);
    rd(4'd3, 32'h2, "tx_stat_after");

    // RX
    send_rx(8'hC3, 1'b1);
    repeat (4) @(negedge clk);
    rd(4'd3, 32'h3, "rx_stat");
    rd(4'd2, 32'hC3, "rx_data");
    rd(4'd3, 32'h2, "rx_stat_clr");

    @(negedge clk);
    rxd = 1'b0;
    repeat (8) @(negedge clk);
    rxd = 1'b1;
    repeat (200) @(negedge clk);
    rd(4'd3, 32'h2, "rx_glitch");

    send_rx(8'hA5, 1'b0);
    repeat (20) @(negedge clk);
    rd(4'd3, 32'h2, "rx_framing");

    send_rx(8'h11, 1'b1);
    send_rx(8'h22, 1'b1);
    repeat (4) @(negedge clk);
    rd(4'd3, 32'h3, "rx_ovr_stat");
    rd(4'd2, 32'h22, "rx_ovr_data");
`endif

    // reset mid-frame with the clock stopped
    wr(4'd1, 32'h81, "pre_rst_led");
    wr(4'd2, 32'h33, "pre_rst_tx");
    repeat (30) @(negedge clk);
    clk_en = 1'b0;
    #2 rst_n = 1'b0;
    #2;
    check("mid_rst_led", {24'd0, led}, 32'h0);
    check("mid_rst_txd", {31'd0, txd}, 32'h1);
    check("mid_rst_ack", {31'd0, ack}, 32'h0);
    #2 rst_n = 1'b1;
    clk_en = 1'b1;
    rd(4'd3, 32'h2, "post_rst_stat");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
